// File: rtl/gun_hit_seq.sv
// Light-gun hit sequencer: debounces the trigger, then blacks the screen and
// flashes each enabled target for one frame while counting photodiode light.
// It reports which targets were seen, or reports ambient light if the black
// frames were already lit.
module gun_hit_seq #(
  parameter int NUM_TARGETS     = 2,
  parameter int BLACK_FRAMES    = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DETECT_MIN      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   trigger,
  input  logic                   detect,
  input  logic [NUM_TARGETS-1:0] target_en,
  output logic                   blank_screen,
  output logic [NUM_TARGETS-1:0] flash_sel,
  output logic                   busy,
  output logic                   hit_valid,
  output logic [NUM_TARGETS-1:0] hit_mask,
  output logic                   ambient
);

  typedef enum logic [2:0] {IDLE, ARM, BLACK, FLASH, REPORT, HOLDOFF} state_t;

  state_t                 state_reg, state_next;
  logic                   trig_meta_reg, trig_sync_reg, det_meta_reg, det_sync_reg;
  logic                   deb_reg, deb_next, press_reg, press_next;
  logic [15:0]            deb_cnt_reg, deb_cnt_next;
  logic [NUM_TARGETS-1:0] shot_mask_reg, shot_mask_next;
  logic [NUM_TARGETS-1:0] hit_acc_reg, hit_acc_next;
  logic                   amb_acc_reg, amb_acc_next;
  logic [2:0]             idx_reg, idx_next;
  logic [3:0]             frame_cnt_reg, frame_cnt_next;
  logic [15:0]            det_cnt_reg, det_cnt_next, det_sum;
  logic                   det_seen;

  logic                   blank_next, busy_next, hit_valid_next, ambient_next;
  logic [NUM_TARGETS-1:0] flash_sel_next, hit_mask_next;

  logic [NUM_TARGETS-1:0] cur_onehot, idx_onehot_next, above_mask;
  logic                   first_found, nxt_found;
  logic [2:0]             first_idx, nxt_idx;

  // Per-target decode: current target, next-cycle target, and enabled targets above the current one.
  for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_tgt
    assign cur_onehot[gi]      = (idx_reg == 3'(gi));
    assign idx_onehot_next[gi] = (idx_next == 3'(gi));
    assign above_mask[gi]      = shot_mask_reg[gi] & (3'(gi) > idx_reg);
  end

  // Priority search for the lowest enabled target and the next enabled target above the current one.
  always_comb begin
    first_found = 1'b0;
    first_idx   = 3'd0;
    nxt_found   = 1'b0;
    nxt_idx     = 3'd0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (shot_mask_reg[i]) begin
        first_found = 1'b1;
        first_idx   = 3'(i);
      end
      if (above_mask[i]) begin
        nxt_found = 1'b1;
        nxt_idx   = 3'(i);
      end
    end
  end

  // Trigger debounce: flip only after the synced input has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    deb_next     = deb_reg;
    deb_cnt_next = 16'd0;
    if (trig_sync_reg != deb_reg) begin
      if (deb_cnt_reg == 16'(DEBOUNCE_CYCLES - 1)) begin
        deb_next = ~deb_reg;
      end else begin
        deb_cnt_next = deb_cnt_reg + 16'd1;
      end
    end
    press_next = deb_next & ~deb_reg;
  end

  // Saturating light count for the current frame, including the current cycle's sample.
  always_comb begin
    det_sum  = (det_cnt_reg == 16'hFFFF) ? det_cnt_reg : det_cnt_reg + {15'd0, det_sync_reg};
    det_seen = (det_sum >= 16'(DETECT_MIN));
  end

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      trig_meta_reg <= 1'b0;
      trig_sync_reg <= 1'b0;
      det_meta_reg  <= 1'b0;
      det_sync_reg  <= 1'b0;
      deb_reg       <= 1'b0;
      deb_cnt_reg   <= 16'd0;
      press_reg     <= 1'b0;
      shot_mask_reg <= '0;
      hit_acc_reg   <= '0;
      amb_acc_reg   <= 1'b0;
      idx_reg       <= 3'd0;
      frame_cnt_reg <= 4'd0;
      det_cnt_reg   <= 16'd0;
      blank_screen  <= 1'b0;
      flash_sel     <= '0;
      busy          <= 1'b0;
      hit_valid     <= 1'b0;
      hit_mask      <= '0;
      ambient       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      trig_meta_reg <= trigger;
      trig_sync_reg <= trig_meta_reg;
      det_meta_reg  <= detect;
      det_sync_reg  <= det_meta_reg;
      deb_reg       <= deb_next;
      deb_cnt_reg   <= deb_cnt_next;
      press_reg     <= press_next;
      shot_mask_reg <= shot_mask_next;
      hit_acc_reg   <= hit_acc_next;
      amb_acc_reg   <= amb_acc_next;
      idx_reg       <= idx_next;
      frame_cnt_reg <= frame_cnt_next;
      det_cnt_reg   <= det_cnt_next;
      blank_screen  <= blank_next;
      flash_sel     <= flash_sel_next;
      busy          <= busy_next;
      hit_valid     <= hit_valid_next;
      hit_mask      <= hit_mask_next;
      ambient       <= ambient_next;
    end
  end

  // Next-state and accumulator logic; each frame_tick is acted on only by the state already active.
  always_comb begin
    state_next     = state_reg;
    shot_mask_next = shot_mask_reg;
    hit_acc_next   = hit_acc_reg;
    amb_acc_next   = amb_acc_reg;
    idx_next       = idx_reg;
    frame_cnt_next = frame_cnt_reg;
    det_cnt_next   = det_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (press_reg) begin
          shot_mask_next = target_en;
          hit_acc_next   = '0;
          amb_acc_next   = 1'b0;
          state_next     = ARM;
        end
      end
      ARM: begin
        det_cnt_next   = 16'd0;
        frame_cnt_next = 4'd0;
        if (frame_tick) state_next = BLACK;
      end
      BLACK: begin
        det_cnt_next = det_sum;
        if (frame_tick) begin
          if (det_seen) amb_acc_next = 1'b1;
          det_cnt_next   = 16'd0;
          frame_cnt_next = frame_cnt_reg + 4'd1;
          if (frame_cnt_reg == 4'(BLACK_FRAMES - 1)) begin
            if (first_found) begin
              idx_next   = first_idx;
              state_next = FLASH;
            end else begin
              state_next = REPORT;
            end
          end
        end
      end
      FLASH: begin
        det_cnt_next = det_sum;
        if (frame_tick) begin
          if (det_seen) hit_acc_next = hit_acc_reg | cur_onehot;
          det_cnt_next = 16'd0;
          if (nxt_found) idx_next = nxt_idx;
          else           state_next = REPORT;
        end
      end
      REPORT:  state_next = HOLDOFF;
      HOLDOFF: if (!deb_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output values derived from the upcoming state so the registered outputs line up with it.
  always_comb begin
    blank_next     = (state_next == BLACK) || (state_next == FLASH);
    flash_sel_next = (state_next == FLASH) ? idx_onehot_next : '0;
    busy_next      = (state_next != IDLE);
    hit_valid_next = (state_next == REPORT);
    hit_mask_next  = hit_mask;
    ambient_next   = ambient;
    if (state_next == REPORT) begin
      hit_mask_next = amb_acc_next ? '0 : hit_acc_next;
      ambient_next  = amb_acc_next;
    end
  end

endmodule

// File: tb/tb_gun_hit_seq.sv
// Directed bench for gun_hit_seq: fixed shots with hand-computed hit/ambient results.
module tb_gun_hit_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       trigger = 1'b0;
  logic       detect = 1'b0;
  logic [1:0] target_en = 2'b00;
  logic       blank_screen, busy, hit_valid, ambient;
  logic [1:0] flash_sel, hit_mask;

  int checks = 0;
  int failures = 0;
  int hv_count = 0;

  gun_hit_seq #(
    .NUM_TARGETS(2), .BLACK_FRAMES(1), .DEBOUNCE_CYCLES(4), .DETECT_MIN(3)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .trigger(trigger),
    .detect(detect), .target_en(target_en), .blank_screen(blank_screen),
    .flash_sel(flash_sel), .busy(busy), .hit_valid(hit_valid),
    .hit_mask(hit_mask), .ambient(ambient)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (hit_valid === 1'b1) hv_count <= hv_count + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  // One frame: detect high for n cycles, quiet padding so the synced samples land, then the tick.
  task automatic frame(input int n);
    for (int k = 0; k < 12; k++) begin
      detect = (k < n);
      cyc();
    end
    detect = 1'b0;
    do_tick();
  endtask

  task automatic press(input string nm);
    int k;
    trigger = 1'b1;
    for (int j = 0; j < 10; j++) cyc();
    trigger = 1'b0;
    k = 0;
    while (busy !== 1'b1 && k < 30) begin
      cyc();
      k++;
    end
    chk({nm, "_press_busy"}, busy, 1);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 40) begin
      cyc();
      k++;
    end
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic shot(input string nm, input logic [1:0] en, input int db, input int d0,
                      input int d1, input logic [1:0] exp_mask, input logic exp_amb);
    target_en = en;
    press(nm);
    target_en = ~en;
    do_tick();
    chk({nm, "_black_blank"}, blank_screen, 1);
    chk({nm, "_black_sel"}, flash_sel, 0);
    frame(db);
    if (en[0]) begin
      chk({nm, "_sel_t0"}, flash_sel, 2'b01);
      chk({nm, "_blank_t0"}, blank_screen, 1);
      frame(d0);
    end
    if (en[1]) begin
      chk({nm, "_sel_t1"}, flash_sel, 2'b10);
      frame(d1);
    end
    chk({nm, "_hit_valid"}, hit_valid, 1);
    chk({nm, "_hit_mask"}, hit_mask, exp_mask);
    chk({nm, "_ambient"}, ambient, exp_amb);
    chk({nm, "_report_sel"}, flash_sel, 0);
    cyc();
    chk({nm, "_hv_drop"}, hit_valid, 0);
    wait_idle(nm);
    chk({nm, "_mask_hold"}, hit_mask, exp_mask);
  endtask

  initial begin
    int hv0;
    // Reset state
    cyc();
    cyc();
    chk("rst_blank", blank_screen, 0);
    chk("rst_sel", flash_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hv", hit_valid, 0);
    chk("rst_mask", hit_mask, 0);
    chk("rst_amb", ambient, 0);
    reset = 1'b1;
    cyc();

    // Light only in target-1 frame
    shot("t1only", 2'b11, 0, 0, 5, 2'b10, 1'b0);
    // Light everywhere -> ambient, no hits
    shot("ambient", 2'b11, 5, 5, 5, 2'b00, 1'b1);
    // Only target 1 alive
    shot("en10", 2'b10, 0, 0, 5, 2'b10, 1'b0);

    // Short trigger glitches never become a press
    hv0 = hv_count;
    for (int r = 0; r < 4; r++) begin
      trigger = 1'b1;
      cyc(); cyc(); cyc();
      trigger = 1'b0;
      cyc(); cyc(); cyc();
      if (r == 1) frame(2);
    end
    for (int j = 0; j < 10; j++) cyc();
    chk("glitch_busy", busy, 0);
    chk("glitch_hv", hv_count, hv0);
    chk("glitch_mask_kept", hit_mask, 2'b10);
    // Two detect cycles per frame is below threshold
    shot("weak", 2'b11, 2, 2, 2, 2'b00, 1'b0);
    // No targets alive: report right after the black frame
    shot("en00", 2'b00, 0, 0, 0, 2'b00, 1'b0);

    // Second press during FLASH, trigger held through REPORT
    hv0 = hv_count;
    target_en = 2'b11;
    press("hold");
    do_tick();
    frame(0);
    chk("hold_sel_t0", flash_sel, 2'b01);
    trigger = 1'b1;
    frame(0);
    chk("hold_sel_t1", flash_sel, 2'b10);
    frame(5);
    chk("hold_hv", hit_valid, 1);
    chk("hold_mask", hit_mask, 2'b10);
    for (int j = 0; j < 20; j++) cyc();
    chk("hold_busy_held", busy, 1);
    trigger = 1'b0;
    cyc(); cyc(); cyc();
    chk("hold_busy_debounce", busy, 1);
    wait_idle("hold");
    for (int j = 0; j < 30; j++) cyc();
    frame(5);
    chk("hold_no_requeue", busy, 0);
    chk("hold_one_report", hv_count, hv0 + 1);

    // Reset asserted mid-FLASH
    target_en = 2'b11;
    press("midrst");
    do_tick();
    frame(0);
    chk("midrst_sel_before", flash_sel, 2'b01);
    reset = 1'b0;
    #1;
    chk("midrst_blank", blank_screen, 0);
    chk("midrst_sel", flash_sel, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_mask", hit_mask, 0);
    chk("midrst_amb", ambient, 0);
    cyc(); cyc();
    reset = 1'b1;
    hv0 = hv_count;
    frame(5);
    frame(5);
    chk("postrst_busy", busy, 0);
    chk("postrst_hv", hv_count, hv0);
    shot("fresh", 2'b11, 0, 0, 5, 2'b10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
